// File: rtl/imem_responder_if.sv
// ---------------------------------------------------------------------------
// imem_responder_if
//
// Instruction-fetch bus between the ifetch stage (master) and the
// instruction-memory responder (slave). One read per word: the master holds
// bus_cyc_i high with a byte address on bus_adr_i. The slave answers with a
// single-cycle bus_ack_o and the fetched word on bus_dat_o.
//
// Signals
//   bus_cyc_i   master -> slave   fetch cycle request (level)
//   bus_adr_i   master -> slave   byte address of the fetch, bits [1:0] ignored
//   bus_ack_o   slave  -> master  one-cycle acknowledge
//   bus_dat_o   slave  -> master  fetched instruction word, valid with ack
// ---------------------------------------------------------------------------
interface imem_responder_if;

    logic        bus_cyc_i;
    logic [31:0] bus_adr_i;
    logic        bus_ack_o;
    logic [31:0] bus_dat_o;

    modport master (
        output bus_cyc_i,
        output bus_adr_i,
        input  bus_ack_o,
        input  bus_dat_o
    );

    modport slave (
        input  bus_cyc_i,
        input  bus_adr_i,
        output bus_ack_o,
        output bus_dat_o
    );

endinterface : imem_responder_if

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//
// Bus responder for the instruction-fetch port. It sits between the ifetch
// stage and a synchronous on-chip instruction RAM with one cycle of read
// latency. Every fetch is answered with a one-cycle acknowledge after
// 2 + WAIT_STATES cycles. A fetch whose address lies beyond the RAM returns
// ILLEGAL_WORD instead of RAM data and raises a sticky fault flag.
//
// Parameters
//   AW            RAM word-address width (depth = 2**AW words), at most 29
//   WAIT_STATES   extra cycles inserted before the acknowledge (0..15)
//   ILLEGAL_WORD  data returned for out-of-range fetches
//
// Ports
//   clk_i         clock
//   rst_ni        asynchronous active-low reset
//   bus           fetch bus (slave side): cyc/adr in, ack/dat out
//   mem_rd_o      RAM read strobe (combinational)
//   mem_adr_o     RAM word address = bus_adr_i[AW+1:2] (combinational)
//   mem_dat_i     RAM read data, valid the cycle after mem_rd_o and held
//   fault_clr_i   clears fault_o and fault_adr_o
//   fault_o       sticky flag: an out-of-range fetch was acknowledged
//   fault_adr_o   byte address of the first out-of-range fetch since clear
//
// Timing: the address is sampled in cycle T (IDLE), the RAM data arrives in
// T+1, the acknowledge is visible in T+2+WAIT_STATES, and the next address
// is sampled one cycle later. One word therefore costs 3+WAIT_STATES cycles.
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned AW           = 10,
    parameter int unsigned WAIT_STATES  = 0,
    parameter logic [31:0] ILLEGAL_WORD = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    imem_responder_if.slave       bus,
    output logic                  mem_rd_o,
    output logic [AW-1:0]         mem_adr_o,
    input  logic [31:0]           mem_dat_i,
    input  logic                  fault_clr_i,
    output logic                  fault_o,
    output logic [31:0]           fault_adr_o
);

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a fetch request
        ST_READ = 2'd1,   // RAM read issued, counting down wait states
        ST_RESP = 2'd2    // acknowledge is on the bus this cycle
    } state_e;

    state_e      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;       // remaining wait states
    logic [31:0] adr_q,      adr_d;       // byte address latched in IDLE
    logic        range_ok_q, range_ok_d;  // range check latched with adr_q
    logic        ack_q,      ack_d;
    logic [31:0] dat_q,      dat_d;
    logic        fault_q,    fault_d;
    logic [31:0] fault_adr_q, fault_adr_d;

    // Any address bit above the RAM's byte range makes the fetch illegal.
    // A shift is used instead of a part-select so the expression stays
    // well-formed for every legal AW.
    logic range_ok;
    assign range_ok = ((bus.bus_adr_i >> (AW + 2)) == 32'd0);

    // The RAM is addressed straight from the bus so the read can be issued
    // in the same cycle the request is first seen.
    assign mem_adr_o = bus.bus_adr_i[AW+1:2];

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would otherwise infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        adr_d       = adr_q;
        range_ok_d  = range_ok_q;
        ack_d       = 1'b0;          // ack is a single-cycle pulse
        dat_d       = dat_q;         // data holds until the next ack
        fault_d     = fault_q;
        fault_adr_d = fault_adr_q;
        mem_rd_o    = 1'b0;

        // Clear first, so a fault raised below in the same cycle overrides it.
        if (fault_clr_i) begin
            fault_d     = 1'b0;
            fault_adr_d = 32'd0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.bus_cyc_i) begin
                    // Out-of-range fetches never touch the RAM.
                    mem_rd_o   = range_ok;
                    adr_d      = bus.bus_adr_i;
                    range_ok_d = range_ok;
                    cnt_d      = 4'(WAIT_STATES);
                    state_d    = ST_READ;
                end
            end

            ST_READ: begin
                if (!bus.bus_cyc_i) begin
                    // Initiator withdrew the request: abandon without ack.
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // mem_dat_i has held the word since the cycle after the
                    // read, so it is still valid however long we waited.
                    dat_d   = range_ok_q ? mem_dat_i : ILLEGAL_WORD;
                    ack_d   = 1'b1;
                    state_d = ST_RESP;
                    if (!range_ok_q) begin
                        fault_d = 1'b1;
                        // Keep the first faulting address, unless it is being
                        // cleared this very cycle.
                        if (!fault_q || fault_clr_i) begin
                            fault_adr_d = adr_q;
                        end
                    end
                end
            end

            ST_RESP: begin
                // The ack is visible now; it is never repeated for this
                // access. If bus_cyc_i is still high, IDLE starts a new one.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the clock edge, independent of order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            adr_q       <= 32'd0;
            range_ok_q  <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= 32'd0;
            fault_q     <= 1'b0;
            fault_adr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adr_q       <= adr_d;
            range_ok_q  <= range_ok_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            fault_q     <= fault_d;
            fault_adr_q <= fault_adr_d;
        end
    end

    assign bus.bus_ack_o = ack_q;
    assign bus.bus_dat_o = dat_q;
    assign fault_o       = fault_q;
    assign fault_adr_o   = fault_adr_q;

    // -----------------------------------------------------------------------
    // Protocol properties
    // -----------------------------------------------------------------------
    // The acknowledge never lasts longer than one cycle.
    ack_single_cycle: assert property (
        @(posedge clk_i) disable iff (!rst_ni) ack_q |=> !ack_q
    );

    // The RAM is only strobed while a new access is being started.
    rd_only_in_idle: assert property (
        @(posedge clk_i) disable iff (!rst_ni) mem_rd_o |-> (state_q == ST_IDLE)
    );

endmodule : imem_responder

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
//
// Two responders share clock and reset: dut0 with no wait states and dut3
// with three. Each has its own behavioural RAM with one cycle read latency.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// on the falling edge. Cycle-by-cycle vectors exercise dut0. Hand-written
// sequences cover wait states, asynchronous reset in READ and RESP, and the
// latency after reset.
// ---------------------------------------------------------------------------
module tb_imem_responder;

    localparam logic [31:0] ILL  = 32'h0BAD_F00D;
    localparam logic [31:0] W0   = 32'h1234_5679;
    localparam logic [31:0] W1   = 32'hDEAD_BEE0;
    localparam logic [31:0] W2   = 32'hCAFE_0002;
    localparam logic [31:0] WTOP = 32'h7777_3FF0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imem_responder_if bus0 ();
    imem_responder_if bus3 ();

    logic        mem_rd0, mem_rd3;
    logic [9:0]  mem_adr0, mem_adr3;
    logic [31:0] mem_dat0, mem_dat3;
    logic        clr0, clr3;
    logic        fault0, fault3;
    logic [31:0] fadr0, fadr3;

    imem_responder #(.AW(10), .WAIT_STATES(0), .ILLEGAL_WORD(ILL)) dut0 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus0.slave),
        .mem_rd_o    (mem_rd0),
        .mem_adr_o   (mem_adr0),
        .mem_dat_i   (mem_dat0),
        .fault_clr_i (clr0),
        .fault_o     (fault0),
        .fault_adr_o (fadr0)
    );

    imem_responder #(.AW(10), .WAIT_STATES(3), .ILLEGAL_WORD(ILL)) dut3 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus3.slave),
        .mem_rd_o    (mem_rd3),
        .mem_adr_o   (mem_adr3),
        .mem_dat_i   (mem_dat3),
        .fault_clr_i (clr3),
        .fault_o     (fault3),
        .fault_adr_o (fadr3)
    );

    // Synchronous RAM model: data appears the cycle after the read strobe
    // and holds until the next read.
    logic [31:0] ram [1024];
    always @(posedge clk) if (mem_rd0) mem_dat0 <= ram[mem_adr0];
    always @(posedge clk) if (mem_rd3) mem_dat3 <= ram[mem_adr3];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cyc;
        logic [31:0] adr;
        logic        clr;
        logic        rd;
        logic        ack;
        logic [31:0] dat;
        logic        flt;
        logic [31:0] fadr;
    } vec_t;

    function automatic vec_t mk(logic cyc, logic [31:0] adr, logic clr, logic rd,
                                logic ack, logic [31:0] dat, logic flt, logic [31:0] fadr);
        vec_t v;
        v.cyc = cyc; v.adr = adr; v.clr = clr; v.rd = rd;
        v.ack = ack; v.dat = dat; v.flt = flt; v.fadr = fadr;
        return v;
    endfunction

    vec_t vecs [35];

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'hA500_0000 | i;
        ram[0]    = W0;
        ram[1]    = W1;
        ram[2]    = W2;
        ram[1023] = WTOP;

        //                cyc adr           clr rd ack dat   flt fadr
        vecs[0]  = mk(1, 32'h0000_0000, 0, 1, 0, 32'h0, 0, 32'h0);  // IDLE: fetch word 0
        vecs[1]  = mk(1, 32'h0000_0000, 0, 0, 0, 32'h0, 0, 32'h0);  // READ
        vecs[2]  = mk(1, 32'h0000_0004, 0, 0, 1, W0,    0, 32'h0);  // ack at cycle 2
        vecs[3]  = mk(1, 32'h0000_0004, 0, 1, 0, W0,    0, 32'h0);  // IDLE: fetch word 1
        vecs[4]  = mk(1, 32'h0000_0004, 0, 0, 0, W0,    0, 32'h0);
        vecs[5]  = mk(1, 32'h0000_0004, 0, 0, 1, W1,    0, 32'h0);  // ack at cycle 5
        vecs[6]  = mk(0, 32'h0000_0004, 0, 0, 0, W1,    0, 32'h0);  // idle, data held
        vecs[7]  = mk(0, 32'h0000_0004, 0, 0, 0, W1,    0, 32'h0);
        vecs[8]  = mk(1, 32'h0000_0004, 0, 1, 0, W1,    0, 32'h0);  // stall: same adr twice
        vecs[9]  = mk(1, 32'h0000_0004, 0, 0, 0, W1,    0, 32'h0);
        vecs[10] = mk(1, 32'h0000_0004, 0, 0, 1, W1,    0, 32'h0);
        vecs[11] = mk(1, 32'h0000_0004, 0, 1, 0, W1,    0, 32'h0);  // fresh access, not a repeat
        vecs[12] = mk(1, 32'h0000_0004, 0, 0, 0, W1,    0, 32'h0);
        vecs[13] = mk(1, 32'h0000_0008, 0, 0, 1, W1,    0, 32'h0);
        vecs[14] = mk(1, 32'h0000_0008, 0, 1, 0, W1,    0, 32'h0);  // start fetch of word 2
        vecs[15] = mk(0, 32'h0000_0008, 0, 0, 0, W1,    0, 32'h0);  // abort in READ
        vecs[16] = mk(0, 32'h0000_0008, 0, 0, 0, W1,    0, 32'h0);  // no ack
        vecs[17] = mk(1, 32'h0000_0008, 0, 1, 0, W1,    0, 32'h0);  // reassert
        vecs[18] = mk(1, 32'h0000_0000, 0, 0, 0, W1,    0, 32'h0);  // adr change ignored
        vecs[19] = mk(1, 32'h0001_0000, 0, 0, 1, W2,    0, 32'h0);  // latched word 2 returned
        vecs[20] = mk(1, 32'h0001_0000, 0, 0, 0, W2,    0, 32'h0);  // out of range: no RAM read
        vecs[21] = mk(1, 32'h0001_0000, 0, 0, 0, W2,    0, 32'h0);
        vecs[22] = mk(1, 32'h0002_0004, 0, 0, 1, ILL,   1, 32'h0001_0000);
        vecs[23] = mk(1, 32'h0002_0004, 0, 0, 0, ILL,   1, 32'h0001_0000);  // second bad adr
        vecs[24] = mk(1, 32'h0002_0004, 0, 0, 0, ILL,   1, 32'h0001_0000);
        vecs[25] = mk(1, 32'h0000_1000, 0, 0, 1, ILL,   1, 32'h0001_0000);  // first adr kept
        vecs[26] = mk(1, 32'h0000_1000, 0, 0, 0, ILL,   1, 32'h0001_0000);  // first adr past top
        vecs[27] = mk(1, 32'h0000_1000, 1, 0, 0, ILL,   1, 32'h0001_0000);  // clear + new fault
        vecs[28] = mk(0, 32'h0000_1000, 0, 0, 1, ILL,   1, 32'h0000_1000);  // new fault wins
        vecs[29] = mk(0, 32'h0000_0000, 1, 0, 0, ILL,   1, 32'h0000_1000);  // plain clear
        vecs[30] = mk(0, 32'h0000_0000, 0, 0, 0, ILL,   0, 32'h0);
        vecs[31] = mk(1, 32'h0000_0FFC, 0, 1, 0, ILL,   0, 32'h0);  // last legal word
        vecs[32] = mk(1, 32'h0000_0FFC, 0, 0, 0, ILL,   0, 32'h0);
        vecs[33] = mk(0, 32'h0000_0FFC, 0, 0, 1, WTOP,  0, 32'h0);
        vecs[34] = mk(0, 32'h0000_0000, 0, 0, 0, WTOP,  0, 32'h0);

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        bus0.bus_cyc_i = 1'b0; bus0.bus_adr_i = 32'h0; clr0 = 1'b0;
        bus3.bus_cyc_i = 1'b0; bus3.bus_adr_i = 32'h0; clr3 = 1'b0;
        #2;
        check("reset ack",   {31'h0, bus0.bus_ack_o}, 32'h0);
        check("reset dat",   bus0.bus_dat_o, 32'h0);
        check("reset rd",    {31'h0, mem_rd0}, 32'h0);
        check("reset fault", {31'h0, fault0}, 32'h0);
        check("reset fadr",  fadr0, 32'h0);
        check("reset ack3",  {31'h0, bus3.bus_ack_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- vector table, WAIT_STATES=0 ----------------
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            bus0.bus_cyc_i = vecs[i].cyc;
            bus0.bus_adr_i = vecs[i].adr;
            clr0           = vecs[i].clr;
            @(negedge clk);
            check($sformatf("v%0d rd", i),    {31'h0, mem_rd0}, {31'h0, vecs[i].rd});
            if (vecs[i].rd)
                check($sformatf("v%0d madr", i), {22'h0, mem_adr0}, {22'h0, vecs[i].adr[11:2]});
            check($sformatf("v%0d ack", i),   {31'h0, bus0.bus_ack_o}, {31'h0, vecs[i].ack});
            check($sformatf("v%0d dat", i),   bus0.bus_dat_o, vecs[i].dat);
            check($sformatf("v%0d fault", i), {31'h0, fault0}, {31'h0, vecs[i].flt});
            check($sformatf("v%0d fadr", i),  fadr0, vecs[i].fadr);
        end

        // ---------------- WAIT_STATES=3, single fetch at adr 8 ----------------
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus3.bus_cyc_i = (k < 5);
            bus3.bus_adr_i = 32'h0000_0008;
            @(negedge clk);
            check($sformatf("ws3 c%0d rd", k),  {31'h0, mem_rd3}, {31'h0, (k == 0)});
            check($sformatf("ws3 c%0d ack", k), {31'h0, bus3.bus_ack_o}, {31'h0, (k == 5)});
            if (k == 5) check("ws3 dat", bus3.bus_dat_o, W2);
        end

        // ---------------- async reset while in READ ----------------
        @(posedge clk); #1;
        bus0.bus_cyc_i = 1'b1; bus0.bus_adr_i = 32'h0;      // IDLE
        @(posedge clk); #1;                                  // now READ
        #2;
        rst_n = 1'b0;
        bus0.bus_cyc_i = 1'b0;
        #1;
        check("rst READ ack", {31'h0, bus0.bus_ack_o}, 32'h0);
        check("rst READ dat", bus0.bus_dat_o, 32'h0);
        @(posedge clk); #1;
        check("rst READ no ack", {31'h0, bus0.bus_ack_o}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- async reset while in RESP ----------------
        @(posedge clk); #1;
        bus0.bus_cyc_i = 1'b1; bus0.bus_adr_i = 32'h0001_0000;
        @(posedge clk); #1;                                  // READ
        @(posedge clk); #1;                                  // RESP
        bus0.bus_cyc_i = 1'b0;
        check("pre RESP ack",   {31'h0, bus0.bus_ack_o}, 32'h1);
        check("pre RESP dat",   bus0.bus_dat_o, ILL);
        check("pre RESP fault", {31'h0, fault0}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst RESP ack",   {31'h0, bus0.bus_ack_o}, 32'h0);
        check("rst RESP dat",   bus0.bus_dat_o, 32'h0);
        check("rst RESP fault", {31'h0, fault0}, 32'h0);
        check("rst RESP fadr",  fadr0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- latency after reset, both DUTs ----------------
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            bus0.bus_cyc_i = (k < 2); bus0.bus_adr_i = 32'h0;
            bus3.bus_cyc_i = (k < 5); bus3.bus_adr_i = 32'h0;
            @(negedge clk);
            check($sformatf("post c%0d ack0", k), {31'h0, bus0.bus_ack_o}, {31'h0, (k == 2)});
            check($sformatf("post c%0d ack3", k), {31'h0, bus3.bus_ack_o}, {31'h0, (k == 5)});
            if (k == 2) check("post dat0", bus0.bus_dat_o, W0);
            if (k == 5) check("post dat3", bus3.bus_dat_o, W0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_imem_responder
